// File: rtl/sopc_scope_sys_trig_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : sopc_scope_sys_trig_ctrl_if
// Brief   : Avalon-MM register bus between the host and the scope trigger
//           controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sopc_scope_sys_trig_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/sopc_scope_sys_trig_ctrl.sv
//------------------------------------------------------------------------------
// Module  : sopc_scope_sys_trig_ctrl
// Brief   : Trigger/capture sequencer. It writes a pre-/post-trigger record of
//           the ADC stream into a circular buffer RAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sopc_scope_sys_trig_ctrl #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sopc_scope_sys_trig_ctrl_if.slave avs,
  input  logic [SAMPLE_W-1:0]       sample,
  input  logic                      sample_valid,
  output logic                      buf_we,
  output logic [ADDR_W-1:0]         buf_addr,
  output logic [SAMPLE_W-1:0]       buf_data,
  output logic                      irq
);

  localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2,
    S_POST  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                slope_q, slope_d;
  logic                auto_q, auto_d;
  logic                irq_en_q, irq_en_d;
  logic [SAMPLE_W-1:0] level_q, level_d;
  logic [ADDR_W-1:0]   pretrig_q, pretrig_d;
  logic [15:0]         timeout_q, timeout_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                done_q, done_d;
  logic                auto_fired_q, auto_fired_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0]   pre_cap_q, pre_cap_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [15:0]         armcnt_q, armcnt_d;
  logic                buf_we_q, buf_we_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [SAMPLE_W-1:0] buf_data_q, buf_data_d;

  logic                w_wr, w_start, w_abort, w_busy, w_cross, w_timeout;
  logic [15:0]         w_arm_inc;
  logic [ADDR_W-1:0]   w_post;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_wr    = avs.chipselect & ~avs.write_n;
  assign w_abort = w_wr && (avs.address == 3'd0) && avs.writedata[1];
  assign w_start = w_wr && (avs.address == 3'd0) && avs.writedata[0] && !avs.writedata[1];
  assign w_busy  = (state_q != S_IDLE);
  assign w_unused = ^avs.writedata[31:16];

  assign w_arm_inc = (armcnt_q == 16'hFFFF) ? armcnt_q : armcnt_q + 16'd1;
  assign w_cross   = prev_valid_q &&
                     (slope_q ? (prev_q > level_q && sample <= level_q)
                              : (prev_q < level_q && sample >= level_q));
  assign w_timeout = auto_q && (timeout_q != 16'd0) && (w_arm_inc >= timeout_q);
  assign w_post    = C_PTR_MAX - pre_cap_q;

  always_comb begin
    state_d      = state_q;
    slope_d      = slope_q;
    auto_d       = auto_q;
    irq_en_d     = irq_en_q;
    level_d      = level_q;
    pretrig_d    = pretrig_q;
    timeout_d    = timeout_q;
    trig_addr_d  = trig_addr_q;
    done_d       = done_q;
    auto_fired_d = auto_fired_q;
    wptr_d       = wptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    pre_cap_d    = pre_cap_q;
    cnt_d        = cnt_q;
    armcnt_d     = armcnt_q;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;

    if (w_wr) begin
      case (avs.address)
        3'd0: begin
          slope_d  = avs.writedata[2];
          auto_d   = avs.writedata[3];
          irq_en_d = avs.writedata[4];
        end
        3'd1: level_d   = avs.writedata[SAMPLE_W-1:0];
        3'd2: pretrig_d = avs.writedata[ADDR_W-1:0];
        3'd3: if (avs.writedata[1]) done_d = 1'b0;
        3'd5: timeout_d = avs.writedata[15:0];
        default: ;
      endcase
    end

    if (w_abort) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (w_start) begin
        wptr_d       = '0;
        prev_valid_d = 1'b0;
        done_d       = 1'b0;
        auto_fired_d = 1'b0;
        pre_cap_d    = pretrig_q;
        cnt_d        = '0;
        armcnt_d     = '0;
        state_d      = (pretrig_q == '0) ? S_ARMED : S_FILL;
      end
    end else if (sample_valid) begin
      buf_we_d     = 1'b1;
      buf_addr_d   = wptr_q;
      buf_data_d   = sample;
      wptr_d       = wptr_q + C_PTR_ONE;
      prev_d       = sample;
      prev_valid_d = 1'b1;
      case (state_q)
        S_FILL: begin
          cnt_d = cnt_q + C_PTR_ONE;
          if (cnt_d == pre_cap_q) state_d = S_ARMED;
        end
        S_ARMED: begin
          armcnt_d = w_arm_inc;
          if (w_cross || w_timeout) begin
            trig_addr_d = wptr_q;
            if (!w_cross) auto_fired_d = 1'b1;
            cnt_d = w_post;
            // A full-depth pre-trigger leaves no post samples to record.
            if (w_post == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          cnt_d = cnt_q - C_PTR_ONE;
          if (cnt_q == C_PTR_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      slope_q      <= 1'b0;
      auto_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      level_q      <= '0;
      pretrig_q    <= '0;
      timeout_q    <= '0;
      trig_addr_q  <= '0;
      done_q       <= 1'b0;
      auto_fired_q <= 1'b0;
      wptr_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pre_cap_q    <= '0;
      cnt_q        <= '0;
      armcnt_q     <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      slope_q      <= slope_d;
      auto_q       <= auto_d;
      irq_en_q     <= irq_en_d;
      level_q      <= level_d;
      pretrig_q    <= pretrig_d;
      timeout_q    <= timeout_d;
      trig_addr_q  <= trig_addr_d;
      done_q       <= done_d;
      auto_fired_q <= auto_fired_d;
      wptr_q       <= wptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      pre_cap_q    <= pre_cap_d;
      cnt_q        <= cnt_d;
      armcnt_q     <= armcnt_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs.address)
      3'd0: w_rdata[4:2]          = {irq_en_q, auto_q, slope_q};
      3'd1: w_rdata[SAMPLE_W-1:0] = level_q;
      3'd2: w_rdata[ADDR_W-1:0]   = pretrig_q;
      3'd3: w_rdata[2:0]          = {auto_fired_q, done_q, w_busy};
      3'd4: w_rdata[ADDR_W-1:0]   = trig_addr_q;
      3'd5: w_rdata[15:0]         = timeout_q;
      default: w_rdata = '0;
    endcase
  end

  assign avs.readdata = w_rdata;
  assign buf_we       = buf_we_q;
  assign buf_addr     = buf_addr_q;
  assign buf_data     = buf_data_q;
  assign irq          = done_q & irq_en_q;

endmodule

`default_nettype wire

// File: tb/tb_sopc_scope_sys_trig_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_sopc_scope_sys_trig_ctrl
// Brief   : Directed self-checking bench for the scope trigger controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sopc_scope_sys_trig_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sample;
  logic       sample_valid;
  logic       buf_we;
  logic [8:0] buf_addr;
  logic [7:0] buf_data;
  logic       irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;
  logic [8:0]  last_addr = '0;
  logic [7:0]  mem [0:511];
  logic [31:0] rd;
  int          n;
  int          base;

  sopc_scope_sys_trig_ctrl_if bus ();

  sopc_scope_sys_trig_ctrl #(.SAMPLE_W(8), .ADDR_W(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs          (bus.slave),
    .sample       (sample),
    .sample_valid (sample_valid),
    .buf_we       (buf_we),
    .buf_addr     (buf_addr),
    .buf_data     (buf_data),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (buf_we) begin
      we_cnt++;
      last_addr = buf_addr;
      mem[buf_addr] = buf_data;
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1 d = bus.readdata;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] s);
    sample = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic ramp_capture(output int cnt);
    logic [31:0] st;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      send(8'(8'h70 + 2 * i));
      cnt++;
      bus_read(3'd3, st);
      if (st[1]) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; sample = '0; sample_valid = 1'b0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({buf_we, buf_addr, buf_data, irq} !== 19'd0) $display("FAIL reset_outputs: got %h want 0", {buf_we, buf_addr, buf_data, irq});
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL reset_status: got %h want 0", rd); else pass_cnt++;
    bus_read(3'd0, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL reset_ctrl: got %h want 0", rd); else pass_cnt++;
  endtask

  task automatic test_rising;
    bus_write(3'd1, 32'h80);
    bus_write(3'd2, 32'd4);
    bus_write(3'd0, 32'h01);
    base = we_cnt;
    ramp_capture(n);
    total_cnt++;
    if (n !== 516) $display("FAIL rise_len: got %0d want 516", n); else pass_cnt++;
    total_cnt++;
    if (we_cnt - base !== 516) $display("FAIL rise_writes: got %0d want 516", we_cnt - base); else pass_cnt++;
    bus_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd8) $display("FAIL rise_trig_addr: got %0d want 8", rd); else pass_cnt++;
    total_cnt++;
    if (last_addr !== 9'd3) $display("FAIL rise_last_addr: got %0d want 3", last_addr); else pass_cnt++;
    total_cnt++;
    if (mem[8] !== 8'h80 || mem[4] !== 8'h78 || mem[3] !== 8'h76)
      $display("FAIL rise_record: got %h %h %h want 80 78 76", mem[8], mem[4], mem[3]);
    else pass_cnt++;
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h2 || irq !== 1'b0) $display("FAIL rise_status: got %h irq %b want 2 irq 0", rd, irq); else pass_cnt++;
    bus_read(3'd2, rd);
    total_cnt++;
    if (rd !== 32'd4) $display("FAIL pretrig_readback: got %0d want 4", rd); else pass_cnt++;
  endtask

  task automatic test_falling;
    bus_write(3'd1, 32'h40);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h05);
    send(8'h50);
    send(8'h48);
    bus_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd8) $display("FAIL fall_early: got %0d want 8", rd); else pass_cnt++;
    send(8'h40);
    bus_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd2) $display("FAIL fall_trig_addr: got %0d want 2", rd); else pass_cnt++;
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL fall_status: got %h want 1", rd); else pass_cnt++;
    bus_write(3'd0, 32'h06);
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL fall_abort: got %h want 0", rd); else pass_cnt++;
  endtask

  task automatic test_auto;
    bus_write(3'd1, 32'h80);
    bus_write(3'd5, 32'd10);
    bus_write(3'd0, 32'h09);
    for (int i = 0; i < 9; i++) send(8'h10);
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL auto_before: got %h want 1", rd); else pass_cnt++;
    send(8'h10);
    bus_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd9) $display("FAIL auto_trig_addr: got %0d want 9", rd); else pass_cnt++;
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h5) $display("FAIL auto_status: got %h want 5", rd); else pass_cnt++;
    bus_read(3'd5, rd);
    total_cnt++;
    if (rd !== 32'd10) $display("FAIL timeout_readback: got %0d want 10", rd); else pass_cnt++;
    bus_write(3'd0, 32'h02);
  endtask

  task automatic test_no_trigger_abort;
    bus_write(3'd0, 32'h01);
    for (int i = 0; i < 21; i++) send(8'h90);
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL flat_busy: got %h want 1", rd); else pass_cnt++;
    base = we_cnt;
    bus_write(3'd0, 32'h02);
    bus.address = 3'd3;
    #1;
    total_cnt++;
    if (bus.readdata !== 32'h0) $display("FAIL abort_busy: got %h want 0", bus.readdata); else pass_cnt++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(8'h70);
    total_cnt++;
    if (we_cnt !== base || buf_we !== 1'b0) $display("FAIL abort_no_we: got %0d writes want 0", we_cnt - base); else pass_cnt++;
  endtask

  task automatic test_irq;
    bus_write(3'd5, 32'd1);
    bus_write(3'd2, 32'h1FF);
    bus_write(3'd0, 32'h19);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      send(8'h10);
      n++;
      bus_read(3'd3, rd);
      if (rd[1]) break;
    end
    total_cnt++;
    if (n !== 512) $display("FAIL irq_len: got %0d want 512", n); else pass_cnt++;
    bus_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd511) $display("FAIL full_pre_trig_addr: got %0d want 511", rd); else pass_cnt++;
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h6 || irq !== 1'b1) $display("FAIL irq_set: got %h irq %b want 6 irq 1", rd, irq); else pass_cnt++;
    bus_write(3'd3, 32'h2);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else pass_cnt++;
    bus_write(3'd0, 32'h13);
    bus_read(3'd3, rd);
    total_cnt++;
    if (rd !== 32'h4) $display("FAIL start_abort: got %h want 4", rd); else pass_cnt++;
    bus_read(3'd0, rd);
    total_cnt++;
    if (rd !== 32'h10) $display("FAIL ctrl_readback: got %h want 10", rd); else pass_cnt++;
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL addr6_read: got %h want 0", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid_post;
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h11);
    send(8'h70);
    send(8'h90);
    for (int i = 0; i < 3; i++) send(8'h90);
    total_cnt++;
    if (buf_we !== 1'b1 || buf_addr !== 9'd4) $display("FAIL post_running: got we %b addr %0d want 1 4", buf_we, buf_addr); else pass_cnt++;
    #2 reset_n = 1'b0;
    bus.address = 3'd3;
    #1;
    total_cnt++;
    if ({buf_we, buf_addr, buf_data, irq} !== 19'd0 || bus.readdata !== 32'd0)
      $display("FAIL async_reset: got %h status %h want 0", {buf_we, buf_addr, buf_data, irq}, bus.readdata);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_write(3'd1, 32'h80);
    bus_write(3'd2, 32'd4);
    bus_write(3'd0, 32'h01);
    ramp_capture(n);
    bus_read(3'd4, rd);
    total_cnt++;
    if (n !== 516 || rd !== 32'd8 || irq !== 1'b0) $display("FAIL after_reset: got len %0d trig %0d irq %b want 516 8 0", n, rd, irq); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_rising;
    test_falling;
    test_auto;
    test_no_trigger_abort;
    test_irq;
    test_reset_mid_post;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
